keypad_emulator: RTL and testbench

Synthesizable 4x4 matrix-keypad model driving the row lines in response to the column scan of the keypad reader. It accepts a key code through a valid/ready handshake and plays back one complete key stroke on the row lines: press bounce, stable hold, release bounce. The bounce pattern is deterministic and LFSR-generated. The block sits in place of the physical keypad for loopback self-test and simulation of the scan/debounce/decode path.

---
 rtl/keypad_emulator.sv | 124 ++++++++++++
 tb/tb_keypad_emulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix keypad model answering the reader's column
// scan with one LFSR-bounced key stroke per accepted key code.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES   = 1024,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] columnas,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [3:0] filas,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_LEN =
    (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] B_LAST =
    CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] H_LAST =
    CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_BOUNCE,
    HELD,
    RELEASE_BOUNCE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [7:0]    lfsr;
  logic          lfsr_fb;
  logic          lfsr_shift;
  logic [3:0]    key_reg;
  logic          contact;
  logic          accept;
  logic [3:0]    row_sel;
  logic [3:0]    col_sel;
  logic          col_hit;
  logic [3:0]    filas_next;

  assign key_ready = (state == IDLE);
  assign busy      = ~key_ready;
  assign accept    = key_valid & key_ready;

  // x^8 + x^6 + x^5 + x^4 + 1
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    state_next = state;
    contact    = 1'b0;
    lfsr_shift = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = NO_BOUNCE ? HELD : PRESS_BOUNCE;
        end
      end
      PRESS_BOUNCE: begin
        contact    = lfsr[0];
        lfsr_shift = 1'b1;
        if (cnt == B_LAST) begin
          state_next = HELD;
        end
      end
      HELD: begin
        contact = 1'b1;
        if (cnt == H_LAST) begin
          state_next = NO_BOUNCE ? IDLE : RELEASE_BOUNCE;
        end
      end
      RELEASE_BOUNCE: begin
        contact    = lfsr[0];
        lfsr_shift = 1'b1;
        if (cnt == B_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the key's own column is sampled, so idle or multi-hot scans
  // fall out naturally.
  assign row_sel    = 4'b1000 >> key_reg[3:2];
  assign col_sel    = 4'b1000 >> key_reg[1:0];
  assign col_hit    = |(columnas & col_sel);
  assign filas_next = (contact & col_hit) ? row_sel : 4'b0000;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      lfsr    <= LFSR_SEED;
      key_reg <= 4'h0;
      filas   <= 4'b0000;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state || state_next == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        key_reg <= key_code;
        lfsr    <= LFSR_SEED;
      end else if (lfsr_shift) begin
        lfsr <= {lfsr[6:0], lfsr_fb};
      end
      filas <= filas_next;
      done  <= (state != IDLE) && (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of stroke timing, gating, bounce
// sequence, busy-ignore, no-bounce build and reset abort.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;

  logic [3:0] a_col = 4'b0000;
  logic       a_valid = 1'b0;
  logic [3:0] a_code = 4'h0;
  logic       a_ready;
  logic [3:0] a_filas;
  logic       a_busy;
  logic       a_done;

  logic [3:0] b_col = 4'b0000;
  logic       b_valid = 1'b0;
  logic [3:0] b_code = 4'h0;
  logic       b_ready;
  logic [3:0] b_filas;
  logic       b_busy;
  logic       b_done;

  int n_cmp = 0;
  int n_bad = 0;
  int dones;

  // Key 6 under columnas 0010, B=4 H=8, seed A5: bounce bits
  // 1,0,1,0 on press and 0,1,1,1 on release, filas lags one cycle.
  logic [3:0] ftbl [18] = '{
    4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4,
    4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0
  };

  always #5 clk = ~clk;

  keypad_emulator #(
    .BOUNCE_CYCLES(4),
    .HOLD_CYCLES(8),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .columnas(a_col),
    .key_valid(a_valid),
    .key_code(a_code),
    .key_ready(a_ready),
    .filas(a_filas),
    .busy(a_busy),
    .done(a_done)
  );

  keypad_emulator #(
    .BOUNCE_CYCLES(0),
    .HOLD_CYCLES(3),
    .LFSR_SEED(8'hA5)
  ) dut0 (
    .clk(clk),
    .n_reset(n_reset),
    .columnas(b_col),
    .key_valid(b_valid),
    .key_code(b_code),
    .key_ready(b_ready),
    .filas(b_filas),
    .busy(b_busy),
    .done(b_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_a(input logic [3:0] code);
    a_code  = code;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    n_reset = 1'b1;
    check("rst_filas", 32'(a_filas), 32'h0);
    check("rst_ready", 32'(a_ready), 32'h1);
    check("rst_busy", 32'(a_busy), 32'h0);
    check("rst_done", 32'(a_done), 32'h0);
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("async_filas", 32'(a_filas), 32'h0);
    check("async_ready", 32'(a_ready), 32'h1);
    check("async_busy", 32'(a_busy), 32'h0);
    step();
    n_reset = 1'b1;

    // full stroke, key 6
    a_col = 4'b0010;
    accept_a(4'h6);
    for (int j = 0; j < 18; j++) begin
      check($sformatf("st_filas%0d", j), 32'(a_filas), 32'(ftbl[j]));
      check($sformatf("st_busy%0d", j), 32'(a_busy), 32'(j < 16));
      check($sformatf("st_rdy%0d", j), 32'(a_ready), 32'(j >= 16));
      check($sformatf("st_done%0d", j), 32'(a_done), 32'(j == 16));
      step();
    end

    // same key again with a column sweep during HELD
    accept_a(4'h6);
    for (int j = 0; j < 18; j++) begin
      logic [3:0] e;
      e = ftbl[j];
      if (j == 6 || j == 7 || j == 9) e = 4'h0;
      check($sformatf("sw_filas%0d", j), 32'(a_filas), 32'(e));
      unique case (j)
        5: a_col = 4'b1000;
        6: a_col = 4'b0100;
        7: a_col = 4'b0010;
        8: a_col = 4'b0001;
        9: a_col = 4'b0010;
        default: ;
      endcase
      step();
    end

    // key 0 with a request for key 9 arriving mid-HELD
    a_col = 4'b1000;
    accept_a(4'h0);
    dones = 0;
    for (int j = 0; j < 22; j++) begin
      logic [3:0] e;
      e = (j < 18 && ftbl[j] != 4'h0) ? 4'h8 : 4'h0;
      check($sformatf("ig_filas%0d", j), 32'(a_filas), 32'(e));
      if (a_done) dones++;
      if (j == 7) begin
        check("ig_ready", 32'(a_ready), 32'h0);
        a_code  = 4'h9;
        a_valid = 1'b1;
      end
      if (j == 8) a_valid = 1'b0;
      step();
    end
    check("ig_dones", 32'(dones), 32'h1);

    // key_valid held: next stroke starts in the done cycle
    a_col   = 4'b0010;
    a_code  = 4'h6;
    a_valid = 1'b1;
    step();
    for (int j = 0; j < 18; j++) begin
      if (j == 16) check("b2b_done", 32'(a_done), 32'h1);
      if (j == 16) check("b2b_idle", 32'(a_busy), 32'h0);
      if (j == 17) begin
        check("b2b_busy", 32'(a_busy), 32'h1);
        check("b2b_dn0", 32'(a_done), 32'h0);
        a_valid = 1'b0;
      end
      step();
    end
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      if (a_done) dones++;
      step();
    end
    check("b2b_dones", 32'(dones), 32'h1);

    // no-bounce build, key A
    b_col   = 4'b0010;
    b_code  = 4'hA;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      logic [3:0] e;
      e = (j >= 1 && j <= 3) ? 4'b0010 : 4'b0000;
      check($sformatf("nb_filas%0d", j), 32'(b_filas), 32'(e));
      check($sformatf("nb_busy%0d", j), 32'(b_busy), 32'(j < 3));
      check($sformatf("nb_done%0d", j), 32'(b_done), 32'(j == 3));
      step();
    end

    // reset during PRESS_BOUNCE
    accept_a(4'h6);
    step();
    check("ab_pre", 32'(a_filas), 32'h4);
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("ab_filas", 32'(a_filas), 32'h0);
    check("ab_busy", 32'(a_busy), 32'h0);
    check("ab_ready", 32'(a_ready), 32'h1);
    check("ab_done", 32'(a_done), 32'h0);
    step();
    n_reset = 1'b1;
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      if (a_done) dones++;
      step();
    end
    check("ab_nodone", 32'(dones), 32'h0);

    // first edge after reset release accepts
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    n_reset = 1'b1;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    check("rel_busy", 32'(a_busy), 32'h1);
    for (int j = 0; j < 20; j++) step();
    check("rel_end", 32'(a_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
